// File: rtl/alt_aeq_dprio_master.sv
// ---------------------------------------------------------------------------
// alt_aeq_dprio_master
//
// Serial DPRIO master for the adaptive-EQ engine. Each accepted read or write
// becomes two 64-bit MDIO-style frames to the transceiver:
//   - an address frame (opcode 00, payload = register address);
//   - a 4-cycle idle gap;
//   - a data frame (opcode 01 = write with the latched data, or 11 = read).
// Each frame is 32 preamble ones, start 00, opcode, PRTAD, DEVAD, turnaround 10
// and a 16-bit payload, sent MSB first. Each serial bit lasts two clocks:
// o_dprioclk is low in the first clock and high in the second. On a read, the
// master holds the data line high from the turnaround onward, and captures the
// transceiver's reply at the end of each payload bit.
//
// Ports
//   i_clock          reconfig clock (only clock)
//   i_reset_n        synchronous active-low reset
//   i_wren/i_rden    request strobes from the engine (write wins if both high)
//   i_addr/i_data    register address and write data, latched on accept
//   o_busy           high from the accepting edge until the transaction ends
//   o_dataout        last read result; held between reads
//   o_dataout_valid  one-cycle pulse when o_dataout is loaded
//   o_dprioclk       serial clock to the transceiver
//   o_dpriodin       serial data to the transceiver
//   i_dpriodout      serial data from the transceiver
//   o_dpriodisable   high whenever no frame is on the wire
// ---------------------------------------------------------------------------
module alt_aeq_dprio_master #(
    parameter logic [4:0] PRTAD = 5'b00000,
    parameter logic [4:0] DEVAD = 5'b00001
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_wren,
    input  logic        i_rden,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_data,
    output logic        o_busy,
    output logic [15:0] o_dataout,
    output logic        o_dataout_valid,
    output logic        o_dprioclk,
    output logic        o_dpriodin,
    input  logic        i_dpriodout,
    output logic        o_dpriodisable
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_GAP  = 3'd2,
        ST_DATA = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t      state_r;
    logic [5:0]  bit_cnt_r;     // index of the frame bit on the wire
    logic        phase_r;       // 0 = clock-low half of the bit, 1 = clock-high half
    logic [1:0]  gap_cnt_r;
    logic [62:0] frame_r;       // bits still to send, next bit at [62]
    logic [15:0] data_r;
    logic        op_write_r;
    logic [14:0] rd_shift_r;    // first 15 payload bits of a read reply
    logic [63:0] addr_frame_s;
    logic [63:0] data_frame_s;

    // Build a complete frame. A read data frame keeps the line high through
    // the turnaround and payload so the transceiver can drive the reply.
    function automatic logic [63:0] build_frame(input logic [1:0]  opcode,
                                                input logic [15:0] payload,
                                                input logic        read_data);
        logic [17:0] tail;
        if (read_data) begin
            tail = 18'h3_FFFF;
        end else begin
            tail = {2'b10, payload};
        end
        return {32'hFFFF_FFFF, 2'b00, opcode, PRTAD, DEVAD, tail};
    endfunction

    // Frame images: the address frame is built straight from i_addr so that its
    // first bit can already be driven on the accepting edge. frame_r then holds
    // the address for the rest of the frame.
    always_comb begin
        addr_frame_s = build_frame(2'b00, i_addr, 1'b0);
        if (op_write_r) begin
            data_frame_s = build_frame(2'b01, data_r, 1'b0);
        end else begin
            data_frame_s = build_frame(2'b11, data_r, 1'b1);
        end
    end

    // Transaction FSM with all serial and handshake outputs registered
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_r         <= ST_IDLE;
            bit_cnt_r       <= 6'd0;
            phase_r         <= 1'b0;
            gap_cnt_r       <= 2'd0;
            frame_r         <= 63'd0;
            data_r          <= 16'h0000;
            op_write_r      <= 1'b0;
            rd_shift_r      <= 15'd0;
            o_busy          <= 1'b0;
            o_dataout       <= 16'h0000;
            o_dataout_valid <= 1'b0;
            o_dprioclk      <= 1'b0;
            o_dpriodin      <= 1'b1;
            o_dpriodisable  <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    o_dataout_valid <= 1'b0;
                    if (i_wren || i_rden) begin
                        state_r        <= ST_ADDR;
                        op_write_r     <= i_wren;
                        data_r         <= i_data;
                        bit_cnt_r      <= 6'd0;
                        phase_r        <= 1'b0;
                        rd_shift_r     <= 15'd0;
                        frame_r        <= addr_frame_s[62:0];
                        o_dpriodin     <= addr_frame_s[63];
                        o_dprioclk     <= 1'b0;
                        o_dpriodisable <= 1'b0;
                        o_busy         <= 1'b1;
                    end else begin
                        o_busy <= 1'b0;
                    end
                end

                ST_ADDR, ST_DATA: begin
                    if (!phase_r) begin
                        phase_r    <= 1'b1;
                        o_dprioclk <= 1'b1;
                    end else begin
                        // Reply bits are captured on the edge that ends the
                        // high phase of each payload bit (bits 48..63).
                        if ((state_r == ST_DATA) && !op_write_r && (bit_cnt_r[5:4] == 2'b11)) begin
                            rd_shift_r <= {rd_shift_r[13:0], i_dpriodout};
                        end else begin
                            rd_shift_r <= rd_shift_r;
                        end
                        phase_r    <= 1'b0;
                        o_dprioclk <= 1'b0;
                        if (bit_cnt_r == 6'd63) begin
                            bit_cnt_r      <= 6'd0;
                            o_dpriodin     <= 1'b1;
                            o_dpriodisable <= 1'b1;
                            if (state_r == ST_ADDR) begin
                                state_r   <= ST_GAP;
                                gap_cnt_r <= 2'd0;
                            end else begin
                                state_r <= ST_DONE;
                                if (!op_write_r) begin
                                    o_dataout       <= {rd_shift_r, i_dpriodout};
                                    o_dataout_valid <= 1'b1;
                                end else begin
                                    o_dataout_valid <= 1'b0;
                                end
                            end
                        end else begin
                            bit_cnt_r  <= bit_cnt_r + 6'd1;
                            o_dpriodin <= frame_r[62];
                            frame_r    <= {frame_r[61:0], 1'b1};
                        end
                    end
                end

                ST_GAP: begin
                    if (gap_cnt_r == 2'd3) begin
                        state_r        <= ST_DATA;
                        bit_cnt_r      <= 6'd0;
                        phase_r        <= 1'b0;
                        frame_r        <= data_frame_s[62:0];
                        o_dpriodin     <= data_frame_s[63];
                        o_dpriodisable <= 1'b0;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 2'd1;
                    end
                end

                ST_DONE: begin
                    state_r         <= ST_IDLE;
                    o_busy          <= 1'b0;
                    o_dataout_valid <= 1'b0;
                end

                default: begin
                    state_r         <= ST_IDLE;
                    o_busy          <= 1'b0;
                    o_dataout_valid <= 1'b0;
                    o_dprioclk      <= 1'b0;
                    o_dpriodin      <= 1'b1;
                    o_dpriodisable  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alt_aeq_dprio_master.sv
// Directed bench for alt_aeq_dprio_master: captures both frames of each
// transaction, acts as the transceiver on reads, and compares against
// hand-computed frame images.
module tb_alt_aeq_dprio_master;

    logic        i_clock = 1'b0;
    logic        i_reset_n;
    logic        i_wren;
    logic        i_rden;
    logic [15:0] i_addr;
    logic [15:0] i_data;
    logic        o_busy;
    logic [15:0] o_dataout;
    logic        o_dataout_valid;
    logic        o_dprioclk;
    logic        o_dpriodin;
    logic        i_dpriodout;
    logic        o_dpriodisable;

    int n_vec = 0;
    int n_err = 0;

    always #5 i_clock = ~i_clock;

    alt_aeq_dprio_master #(.PRTAD(5'b00000), .DEVAD(5'b00001)) dut (
        .i_clock         (i_clock),
        .i_reset_n       (i_reset_n),
        .i_wren          (i_wren),
        .i_rden          (i_rden),
        .i_addr          (i_addr),
        .i_data          (i_data),
        .o_busy          (o_busy),
        .o_dataout       (o_dataout),
        .o_dataout_valid (o_dataout_valid),
        .o_dprioclk      (o_dprioclk),
        .o_dpriodin      (o_dpriodin),
        .i_dpriodout     (i_dpriodout),
        .o_dpriodisable  (o_dpriodisable)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with a request already driven. Cycle 0 is the first
    // cycle after the accepting edge; 0..127 address frame, 128..131 gap,
    // 132..259 data frame, 260 done, 261 idle again.
    task automatic run_txn(input logic [15:0] rd_payload, input int poke_at,
                           output logic [63:0] f_addr, output logic [63:0] f_data,
                           output int busy_cyc, output int valid_cyc, output int valid_at,
                           output logic [15:0] dout_v, output logic shape_ok, output logic idle_ok);
        int   j;
        logic last_din;
        f_addr = 64'd0; f_data = 64'd0; busy_cyc = 0; valid_cyc = 0; valid_at = -1;
        dout_v = 16'h0000; shape_ok = 1'b1; idle_ok = 1'b1; last_din = 1'b1;
        for (int i = 0; i <= 261; i++) begin
            @(negedge i_clock);
            if (i == 0) begin
                i_wren = 1'b0;
                i_rden = 1'b0;
            end
            if (i == poke_at) begin
                i_wren = 1'b1;
                i_addr = 16'hFFFF;
                i_data = 16'h5555;
            end
            if (i == poke_at + 1) i_wren = 1'b0;
            if (o_busy === 1'b1) busy_cyc++;
            if (o_dataout_valid === 1'b1) begin
                valid_cyc++;
                valid_at = i;
                dout_v = o_dataout;
            end
            if (i < 128 || (i >= 132 && i < 260)) begin
                j = (i < 128) ? i : i - 132;
                if (o_dprioclk !== j[0] || o_dpriodisable !== 1'b0) shape_ok = 1'b0;
                if (!j[0]) begin
                    if (i < 128) f_addr = {f_addr[62:0], o_dpriodin};
                    else         f_data = {f_data[62:0], o_dpriodin};
                    last_din = o_dpriodin;
                    if (i >= 132 && (j / 2) >= 48) i_dpriodout = rd_payload[63 - (j / 2)];
                end else if (o_dpriodin !== last_din) begin
                    shape_ok = 1'b0;
                end
            end else begin
                if (o_dprioclk !== 1'b0 || o_dpriodin !== 1'b1 || o_dpriodisable !== 1'b1) idle_ok = 1'b0;
            end
        end
        i_dpriodout = 1'b1;
    endtask

    logic [63:0] fa, fd;
    int          bc, vc, va;
    logic [15:0] dv;
    logic        sok, iok;
    int          quiet;

    initial begin
        i_reset_n = 1'b0; i_wren = 1'b0; i_rden = 1'b0;
        i_addr = 16'h0000; i_data = 16'h0000; i_dpriodout = 1'b1;
        repeat (3) @(negedge i_clock);
        chk("reset_outputs", {o_busy, o_dataout, o_dataout_valid, o_dprioclk, o_dpriodin, o_dpriodisable},
            {1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1});
        i_reset_n = 1'b1;
        @(negedge i_clock);

        // Write 0C5A <- BEEF
        i_wren = 1'b1; i_addr = 16'h0C5A; i_data = 16'hBEEF;
        run_txn(16'h0000, -10, fa, fd, bc, vc, va, dv, sok, iok);
        chk("wr_addr_frame", fa, 64'hFFFF_FFFF_0006_0C5A);
        chk("wr_data_frame", fd, 64'hFFFF_FFFF_1006_BEEF);
        chk("wr_busy_cycles", bc, 64'd261);
        chk("wr_no_valid", vc, 64'd0);
        chk("wr_bit_shape", sok, 64'd1);
        chk("wr_idle_lines", iok, 64'd1);
        chk("wr_dataout_held", o_dataout, 64'h0000);

        // Read 0003, transceiver replies A5C3
        i_rden = 1'b1; i_addr = 16'h0003;
        run_txn(16'hA5C3, -10, fa, fd, bc, vc, va, dv, sok, iok);
        chk("rd_addr_frame", fa, 64'hFFFF_FFFF_0006_0003);
        chk("rd_data_frame", fd, 64'hFFFF_FFFF_3007_FFFF);
        chk("rd_busy_cycles", bc, 64'd261);
        chk("rd_valid_count", vc, 64'd1);
        chk("rd_valid_cycle", va, 64'd260);
        chk("rd_dataout", dv, 64'hA5C3);
        chk("rd_bit_shape", sok, 64'd1);
        chk("rd_idle_lines", iok, 64'd1);

        // Collision: write wins
        i_wren = 1'b1; i_rden = 1'b1; i_addr = 16'h0011; i_data = 16'h1234;
        run_txn(16'h0000, -10, fa, fd, bc, vc, va, dv, sok, iok);
        chk("col_addr_frame", fa, 64'hFFFF_FFFF_0006_0011);
        chk("col_data_frame", fd, 64'hFFFF_FFFF_1006_1234);
        chk("col_no_valid", vc, 64'd0);
        chk("col_dataout_held", o_dataout, 64'hA5C3);

        // Second write at cycle 50 is ignored
        i_wren = 1'b1; i_addr = 16'h0020; i_data = 16'h00AA;
        run_txn(16'h0000, 50, fa, fd, bc, vc, va, dv, sok, iok);
        chk("ign_addr_frame", fa, 64'hFFFF_FFFF_0006_0020);
        chk("ign_data_frame", fd, 64'hFFFF_FFFF_1006_00AA);
        chk("ign_busy_cycles", bc, 64'd261);
        quiet = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clock);
            if (o_busy === 1'b0 && o_dpriodisable === 1'b1) quiet++;
        end
        chk("ign_no_third_frame", quiet, 64'd6);

        // Back-to-back: write, then read accepted on the first edge after busy falls
        i_wren = 1'b1; i_addr = 16'h0100; i_data = 16'hCAFE;
        run_txn(16'h0000, -10, fa, fd, bc, vc, va, dv, sok, iok);
        chk("b2b_wr_data_frame", fd, 64'hFFFF_FFFF_1006_CAFE);
        chk("b2b_dataout_after_wr", o_dataout, 64'hA5C3);
        i_rden = 1'b1; i_addr = 16'h0200;
        @(posedge i_clock);
        #1;
        chk("b2b_rd_accepted", o_busy, 64'd1);
        run_txn(16'h3C96, -10, fa, fd, bc, vc, va, dv, sok, iok);
        chk("b2b_rd_addr_frame", fa, 64'hFFFF_FFFF_0006_0200);
        chk("b2b_rd_dataout", dv, 64'h3C96);
        chk("b2b_rd_busy_cycles", bc, 64'd261);

        // Reset at bit 40 of a read data frame
        i_rden = 1'b1; i_addr = 16'h0007;
        for (int i = 0; i <= 212; i++) begin
            @(negedge i_clock);
            if (i == 0) i_rden = 1'b0;
        end
        i_reset_n = 1'b0;
        @(negedge i_clock);
        chk("midrst_outputs", {o_busy, o_dataout, o_dataout_valid, o_dprioclk, o_dpriodin, o_dpriodisable},
            {1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1});
        i_reset_n = 1'b1;
        @(negedge i_clock);
        i_wren = 1'b1; i_addr = 16'h0ABC; i_data = 16'h0DEF;
        run_txn(16'h0000, -10, fa, fd, bc, vc, va, dv, sok, iok);
        chk("post_rst_addr_frame", fa, 64'hFFFF_FFFF_0006_0ABC);
        chk("post_rst_data_frame", fd, 64'hFFFF_FFFF_1006_0DEF);
        chk("post_rst_busy_cycles", bc, 64'd261);
        chk("post_rst_shape", {sok, iok}, 64'd3);
        chk("post_rst_dataout", o_dataout, 64'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
